// File: rtl/lz77_pkg.sv
// Shared constants and state encoding for the LZ77 encoder.
package lz77_pkg;
  localparam int SB_LEN = 30;
  localparam int LA_LEN = 8;
  localparam int POS_W  = 5;
  localparam int LEN_W  = 5;
  localparam int LA_IW  = 3;
  localparam int CNT_W  = 4;
  localparam logic [7:0] TERM = 8'h24;

  typedef enum logic [2:0] {
    FILL, SEARCH, EMIT, SHIFT, DONE
  } state_e;
endpackage

// File: rtl/lz77_match_len.sv
// Match length of the look-ahead against search position p.
module lz77_match_len
  import lz77_pkg::*;
(
  input  logic [3:0]       sb_i [SB_LEN],
  input  logic [3:0]       la_i [LA_LEN],
  input  logic [POS_W-1:0] p_i,
  input  logic [LEN_W-1:0] limit_i,
  output logic [LEN_W-1:0] len_o
);
  always_comb begin
    logic [POS_W-1:0] jp;
    logic [3:0] src;
    logic run;
    jp = '0;
    src = '0;
    run = 1'b1;
    len_o = '0;
    for (int j = 0; j < LA_LEN; j++) begin
      jp = POS_W'(j);
      // Offsets past p run into the look-ahead itself.
      if (jp <= p_i) src = sb_i[p_i - jp];
      else src = la_i[LA_IW'(jp - p_i - 1'b1)];
      if (run && LEN_W'(j) < limit_i && src == la_i[j])
        len_o = len_o + 1'b1;
      else
        run = 1'b0;
    end
  end
endmodule

// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder: fill look-ahead, search, emit triple, shift.
module lz77_encoder
  import lz77_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       chardata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] code_pos,
  output logic [LEN_W-1:0] code_len,
  output logic [7:0]       char_nxt,
  output logic             encode,
  output logic             finish
);
  state_e state_q, state_d;
  logic [3:0] sb_q [SB_LEN];
  logic [7:0] la_q [LA_LEN];
  logic [3:0] la_nib [LA_LEN];
  logic [CNT_W-1:0] la_cnt_q, n_q;
  logic [POS_W-1:0] p_q, best_p_q;
  logic [LEN_W-1:0] best_len_q, cur_len, limit;
  logic term_q, enc_q, in_fire, out_fire;
  logic [7:0] nxt;

  assign in_ready  = (state_q == FILL) && !term_q;
  assign out_valid = (state_q == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign nxt       = la_q[best_len_q[LA_IW-1:0]];
  assign code_pos  = out_valid ? best_p_q : '0;
  assign code_len  = out_valid ? best_len_q : '0;
  assign char_nxt  = out_valid ? nxt : '0;
  assign encode    = enc_q;
  assign finish    = (state_q == DONE);

  always_comb begin
    logic found;
    found = 1'b0;
    limit = LEN_W'(la_cnt_q) - 1'b1;
    for (int i = 0; i < LA_LEN; i++) begin
      la_nib[i] = la_q[i][3:0];
      if (!found && CNT_W'(i) < la_cnt_q && la_q[i] == TERM) begin
        limit = LEN_W'(i);
        found = 1'b1;
      end
    end
  end

  lz77_match_len u_match (
    .sb_i    (sb_q),
    .la_i    (la_nib),
    .p_i     (p_q),
    .limit_i (limit),
    .len_o   (cur_len)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:
        if (in_fire && (chardata == TERM ||
            la_cnt_q == CNT_W'(LA_LEN - 1)))
          state_d = SEARCH;
      SEARCH:
        if (p_q == POS_W'(SB_LEN - 1)) state_d = EMIT;
      EMIT:
        if (out_fire) state_d = (nxt == TERM) ? DONE : SHIFT;
      SHIFT:
        if (n_q == CNT_W'(1))
          state_d = (term_q && la_cnt_q != CNT_W'(1))
                    ? SEARCH : FILL;
      DONE: state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      la_cnt_q   <= '0;
      n_q        <= '0;
      p_q        <= '0;
      best_p_q   <= '0;
      best_len_q <= '0;
      term_q     <= 1'b0;
      enc_q      <= 1'b0;
      for (int i = 0; i < SB_LEN; i++) sb_q[i] <= '0;
      for (int i = 0; i < LA_LEN; i++) la_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FILL: begin
          p_q        <= '0;
          best_p_q   <= '0;
          best_len_q <= '0;
          if (in_fire) begin
            la_q[la_cnt_q[LA_IW-1:0]] <= chardata;
            la_cnt_q <= la_cnt_q + 1'b1;
            enc_q    <= 1'b1;
            if (chardata == TERM) term_q <= 1'b1;
          end
        end
        SEARCH: begin
          p_q <= p_q + 1'b1;
          // Strictly greater keeps the nearest offset on ties.
          if (cur_len > best_len_q) begin
            best_len_q <= cur_len;
            best_p_q   <= p_q;
          end
        end
        EMIT: begin
          if (out_fire) begin
            n_q <= CNT_W'(best_len_q) + 1'b1;
            if (nxt == TERM) enc_q <= 1'b0;
          end
        end
        SHIFT: begin
          p_q        <= '0;
          best_p_q   <= '0;
          best_len_q <= '0;
          for (int i = SB_LEN - 1; i > 0; i--) sb_q[i] <= sb_q[i-1];
          sb_q[0] <= la_q[0][3:0];
          for (int i = 0; i < LA_LEN - 1; i++) la_q[i] <= la_q[i+1];
          la_q[LA_LEN-1] <= '0;
          la_cnt_q <= la_cnt_q - 1'b1;
          n_q      <= n_q - 1'b1;
        end
        default: enc_q <= 1'b0;
      endcase
    end
  end
endmodule
